// File: rtl/ex_mem_reg_if.sv
// EX -> MEM pipeline register bus: EX-side payload and handshake plus MEM-side outputs.
// The master modport is the surrounding pipeline; the slave modport is the register.
interface ex_mem_reg_if #(
  parameter int XLEN = 32
) ();
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_alu_out;
  logic [XLEN-1:0] ex_rs2o;
  logic [4:0]      ex_rdaddr;
  logic            ex_memwr;
  logic            ex_regwr;
  logic [1:0]      ex_wbsel;
  logic [2:0]      ex_func3;
  logic            flush;
  logic            mem_stall;
  logic            mem_valid;
  logic [XLEN-1:0] mem_alu_out;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic [4:0]      mem_rdaddr;
  logic            mem_memwr;
  logic            mem_regwr;
  logic [1:0]      mem_wbsel;
  logic [2:0]      mem_func3;
  logic            mem_misalign;

  modport master (
    output ex_valid, ex_alu_out, ex_rs2o, ex_rdaddr, ex_memwr, ex_regwr,
           ex_wbsel, ex_func3, flush, mem_stall,
    input  ex_ready, mem_valid, mem_alu_out, mem_wdata, mem_be, mem_rdaddr,
           mem_memwr, mem_regwr, mem_wbsel, mem_func3, mem_misalign
  );

  modport slave (
    input  ex_valid, ex_alu_out, ex_rs2o, ex_rdaddr, ex_memwr, ex_regwr,
           ex_wbsel, ex_func3, flush, mem_stall,
    output ex_ready, mem_valid, mem_alu_out, mem_wdata, mem_be, mem_rdaddr,
           mem_memwr, mem_regwr, mem_wbsel, mem_func3, mem_misalign
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer so MEM stalls never
// feed a combinational ready path back into EX; also forms store byte-enables.
module ex_mem_reg #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_mem_reg_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic [4:0]      rdaddr;
    logic            memwr;
    logic            regwr;
    logic [1:0]      wbsel;
    logic [2:0]      func3;
    logic            misalign;
  } payload_t;

  payload_t in_pl;
  payload_t slot_pl;
  payload_t skid_pl;
  logic     slot_valid;
  logic     skid_valid;
  logic     accept;
  logic     refill;
  logic [1:0] addr_lo;

  assign addr_lo = bus.ex_alu_out[1:0];

  // Size decode and lane replication happen before the register so MEM sees them flopped.
  always_comb begin
    in_pl          = '0;
    in_pl.alu_out  = bus.ex_alu_out;
    in_pl.rdaddr   = bus.ex_rdaddr;
    in_pl.memwr    = bus.ex_memwr;
    in_pl.regwr    = bus.ex_regwr;
    in_pl.wbsel    = bus.ex_wbsel;
    in_pl.func3    = bus.ex_func3;
    in_pl.wdata    = bus.ex_rs2o;
    case (bus.ex_func3[1:0])
      2'b00: begin
        in_pl.be       = 4'b0001 << addr_lo;
        in_pl.wdata    = {4{bus.ex_rs2o[7:0]}};
        in_pl.misalign = 1'b0;
      end
      2'b01: begin
        in_pl.be       = 4'b0011 << {addr_lo[1], 1'b0};
        in_pl.wdata    = {2{bus.ex_rs2o[15:0]}};
        in_pl.misalign = addr_lo[0];
      end
      2'b10: begin
        in_pl.be       = 4'b1111;
        in_pl.misalign = |addr_lo;
      end
      default: begin
        in_pl.be       = 4'b0000;
        in_pl.misalign = 1'b1;
      end
    endcase
    if (in_pl.misalign)
      in_pl.be = 4'b0000;
  end

  assign bus.ex_ready = ~skid_valid;
  assign accept       = bus.ex_valid & ~skid_valid;
  assign refill       = ~slot_valid | ~bus.mem_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_pl    <= '0;
      skid_pl    <= '0;
      slot_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (bus.flush) begin
      slot_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (refill) begin
      // A full skid forces ex_ready low, so no input can compete with it here.
      if (skid_valid) begin
        slot_pl    <= skid_pl;
        slot_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        slot_pl    <= in_pl;
        slot_valid <= 1'b1;
      end else begin
        slot_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_pl    <= in_pl;
      skid_valid <= 1'b1;
    end
  end

  assign bus.mem_valid    = slot_valid;
  assign bus.mem_alu_out  = slot_pl.alu_out;
  assign bus.mem_wdata    = slot_pl.wdata;
  assign bus.mem_be       = slot_pl.be;
  assign bus.mem_rdaddr   = slot_pl.rdaddr;
  assign bus.mem_memwr    = slot_pl.memwr & slot_valid & ~slot_pl.misalign;
  assign bus.mem_regwr    = slot_pl.regwr & slot_valid;
  assign bus.mem_wbsel    = slot_pl.wbsel;
  assign bus.mem_func3    = slot_pl.func3;
  assign bus.mem_misalign = slot_pl.misalign;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg: streaming, byte enables,
// misalignment, skid ordering, flush and asynchronous reset while stalled.
module tb_ex_mem_reg;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ex_mem_reg_if #(.XLEN(32)) bus ();

  ex_mem_reg #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic mw, input logic rw,
                       input logic [1:0] wb, input logic [2:0] f3);
    bus.ex_valid   = v;
    bus.ex_alu_out = alu;
    bus.ex_rs2o    = rs2;
    bus.ex_rdaddr  = rd;
    bus.ex_memwr   = mw;
    bus.ex_regwr   = rw;
    bus.ex_wbsel   = wb;
    bus.ex_func3   = f3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.mem_stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 3'd0);

    // Reset held: outputs cleared before and after edges.
    #3;
    chk("rst_valid", bus.mem_valid, 0);
    chk("rst_ready", bus.ex_ready, 1);
    chk("rst_alu", bus.mem_alu_out, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_be", bus.mem_be, 0);
    chk("rst_ctl", {bus.mem_rdaddr, bus.mem_memwr, bus.mem_regwr, bus.mem_wbsel,
                    bus.mem_func3, bus.mem_misalign}, 0);
    step();
    step();
    chk("rst_valid2", bus.mem_valid, 0);
    rst = 1'b1;

    // Eight aligned word stores back to back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(4*i), 32'h11110000 + 32'(i), 5'(i+1), 1'b1, 1'b0, 2'd0, 3'b010);
      step();
      chk("str_valid", bus.mem_valid, 1);
      chk("str_alu", bus.mem_alu_out, 32'h100 + 32'(4*i));
      chk("str_wdata", bus.mem_wdata, 32'h11110000 + 32'(i));
      chk("str_be", bus.mem_be, 4'b1111);
      chk("str_rd", bus.mem_rdaddr, 32'(i+1));
      chk("str_memwr", bus.mem_memwr, 1);
      chk("str_ready", bus.ex_ready, 1);
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 3'd0);
    step();
    chk("bubble_valid", bus.mem_valid, 0);
    chk("bubble_memwr", bus.mem_memwr, 0);

    // Byte store at offset 3.
    drive(1'b1, 32'h1003, 32'h000000AB, 5'd0, 1'b1, 1'b0, 2'd0, 3'b000);
    step();
    chk("sb_be", bus.mem_be, 4'b1000);
    chk("sb_wdata", bus.mem_wdata, 32'hABABABAB);
    chk("sb_memwr", bus.mem_memwr, 1);
    chk("sb_mis", bus.mem_misalign, 0);

    // Half store at offset 2.
    drive(1'b1, 32'h1002, 32'h00001234, 5'd0, 1'b1, 1'b0, 2'd0, 3'b001);
    step();
    chk("sh_be", bus.mem_be, 4'b1100);
    chk("sh_wdata", bus.mem_wdata, 32'h12341234);
    chk("sh_memwr", bus.mem_memwr, 1);

    // Misaligned word store.
    drive(1'b1, 32'h1001, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 2'd0, 3'b010);
    step();
    chk("sw_mis", bus.mem_misalign, 1);
    chk("sw_be", bus.mem_be, 0);
    chk("sw_memwr", bus.mem_memwr, 0);
    chk("sw_valid", bus.mem_valid, 1);

    // Misaligned half store.
    drive(1'b1, 32'h1003, 32'h00005678, 5'd0, 1'b1, 1'b0, 2'd0, 3'b001);
    step();
    chk("shm_mis", bus.mem_misalign, 1);
    chk("shm_be", bus.mem_be, 0);
    chk("shm_memwr", bus.mem_memwr, 0);

    // Unsigned byte load: register write, no store strobe, be still computed.
    drive(1'b1, 32'h2002, 32'h0, 5'd7, 1'b0, 1'b1, 2'd1, 3'b100);
    step();
    chk("lbu_regwr", bus.mem_regwr, 1);
    chk("lbu_memwr", bus.mem_memwr, 0);
    chk("lbu_be", bus.mem_be, 4'b0100);
    chk("lbu_ctl", {bus.mem_rdaddr, bus.mem_wbsel, bus.mem_func3}, {5'd7, 2'd1, 3'b100});

    // Skid: A in slot, B captured while stalled, C waits in EX.
    drive(1'b1, 32'h3000, 32'h0, 5'd10, 1'b0, 1'b1, 2'd0, 3'b010);
    step();
    chk("skA_alu", bus.mem_alu_out, 32'h3000);
    drive(1'b1, 32'h3004, 32'h0, 5'd11, 1'b0, 1'b1, 2'd0, 3'b010);
    bus.mem_stall = 1'b1;
    step();
    chk("skB_ready", bus.ex_ready, 0);
    chk("skB_hold", bus.mem_alu_out, 32'h3000);
    drive(1'b1, 32'h3008, 32'h0, 5'd12, 1'b0, 1'b1, 2'd0, 3'b010);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("sk_hold_alu", bus.mem_alu_out, 32'h3000);
      chk("sk_hold_rd", bus.mem_rdaddr, 10);
      chk("sk_hold_valid", bus.mem_valid, 1);
      chk("sk_hold_ready", bus.ex_ready, 0);
    end
    bus.mem_stall = 1'b0;
    step();
    chk("skB_out", bus.mem_alu_out, 32'h3004);
    chk("skB_rd", bus.mem_rdaddr, 11);
    chk("skB_ready2", bus.ex_ready, 1);
    step();
    chk("skC_out", bus.mem_alu_out, 32'h3008);
    chk("skC_rd", bus.mem_rdaddr, 12);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 3'd0);
    step();
    chk("sk_empty", bus.mem_valid, 0);

    // Flush with slot and skid full under stall.
    drive(1'b1, 32'h4000, 32'h55, 5'd13, 1'b1, 1'b1, 2'd0, 3'b010);
    step();
    drive(1'b1, 32'h4004, 32'h66, 5'd14, 1'b1, 1'b1, 2'd0, 3'b010);
    bus.mem_stall = 1'b1;
    step();
    chk("fl_ready_pre", bus.ex_ready, 0);
    drive(1'b1, 32'h4008, 32'h77, 5'd15, 1'b1, 1'b1, 2'd0, 3'b010);
    bus.flush = 1'b1;
    step();
    chk("fl_valid", bus.mem_valid, 0);
    chk("fl_regwr", bus.mem_regwr, 0);
    chk("fl_memwr", bus.mem_memwr, 0);
    chk("fl_ready", bus.ex_ready, 1);
    bus.flush = 1'b0;
    bus.mem_stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 3'd0);
    step();
    chk("fl_gone", bus.mem_valid, 0);
    step();
    chk("fl_gone2", bus.mem_valid, 0);

    // Asynchronous reset between edges while stalled with the skid full.
    drive(1'b1, 32'h5000, 32'h1, 5'd16, 1'b1, 1'b1, 2'd2, 3'b010);
    step();
    drive(1'b1, 32'h5004, 32'h2, 5'd17, 1'b1, 1'b1, 2'd2, 3'b010);
    bus.mem_stall = 1'b1;
    step();
    chk("ar_ready_pre", bus.ex_ready, 0);
    chk("ar_valid_pre", bus.mem_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", bus.mem_valid, 0);
    chk("ar_alu", bus.mem_alu_out, 0);
    chk("ar_wr", {bus.mem_regwr, bus.mem_memwr}, 0);
    chk("ar_be", bus.mem_be, 0);
    chk("ar_ready", bus.ex_ready, 1);
    #1;
    rst = 1'b1;
    bus.mem_stall = 1'b0;
    drive(1'b1, 32'h6000, 32'h9, 5'd18, 1'b0, 1'b1, 2'd0, 3'b010);
    step();
    chk("post_alu", bus.mem_alu_out, 32'h6000);
    chk("post_regwr", bus.mem_regwr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
